// File: rtl/fx2_shift_pipe_if.sv
// fx2_shift_pipe_if: issue-side operands and controls plus the forwarding
// and writeback taps of the FX2 shift/rotate pipe.
// The master drives the issue side; the slave (the pipe) drives the taps.
interface fx2_shift_pipe_if #(
    parameter int RT_W = 7
);
    logic                  issue_vld;
    logic [2:0]            issue_op;
    logic [RT_W-1:0]       issue_rt;
    logic [0:127]          ra;
    logic [0:127]          rb;
    logic [6:0]            imm7;
    logic                  stall;
    logic                  flush;

    logic [0:3]            fwd_vld;
    logic [0:4*RT_W-1]     fwd_rt;
    logic [0:511]          fwd_data;
    logic                  wb_vld;
    logic [RT_W-1:0]       wb_rt;
    logic [0:127]          wb_data;

    modport master (
        output issue_vld, issue_op, issue_rt, ra, rb, imm7, stall, flush,
        input  fwd_vld, fwd_rt, fwd_data, wb_vld, wb_rt, wb_data
    );

    modport slave (
        input  issue_vld, issue_op, issue_rt, ra, rb, imm7, stall, flush,
        output fwd_vld, fwd_rt, fwd_data, wb_vld, wb_rt, wb_data
    );
endinterface

// File: rtl/fx2_shift_pipe.sv
// fx2_shift_pipe: FX2 execution stage for per-word / per-halfword shift and
// rotate ops. The result is computed from the issuing operands and captured
// in stage 1, then carried unchanged through stages 2..4; stage 4 is the
// writeback port. Bit 0 is the MSB and "left" means toward bit 0.
// Build option: define FX2_ROTM_EN to include ROTM (op 6, logical shift
// right by the negated count). Without it op 6 produces a valid zero result,
// the same as the reserved op 7.
module fx2_shift_pipe #(
    parameter int LAT  = 4,
    parameter int RT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    fx2_shift_pipe_if.slave pipe
);

    localparam logic [2:0] OP_SHL  = 3'd0;
    localparam logic [2:0] OP_SHLH = 3'd1;
    localparam logic [2:0] OP_SHLI = 3'd2;
    localparam logic [2:0] OP_ROT  = 3'd3;
    localparam logic [2:0] OP_ROTH = 3'd4;
    localparam logic [2:0] OP_ROTI = 3'd5;
`ifdef FX2_ROTM_EN
    localparam logic [2:0] OP_ROTM = 3'd6;
`endif

    // Word shift left; counts of 32..63 clear the word.
    function automatic logic [31:0] shl_w(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] c;
        c = b & 32'h0000_003F;
        return (c >= 32'd32) ? 32'h0 : (a << c);
    endfunction

    // Halfword shift left; counts of 16..31 clear the halfword.
    function automatic logic [15:0] shl_h(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] c;
        c = b & 16'h001F;
        return (c >= 16'd16) ? 16'h0 : (a << c);
    endfunction

    // Word rotate left; a zero count makes the right-shift term vanish.
    function automatic logic [31:0] rot_w(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] c;
        c = b & 32'h0000_001F;
        return (a << c) | (a >> (32'd32 - c));
    endfunction

    // Halfword rotate left.
    function automatic logic [15:0] rot_h(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] c;
        c = b & 16'h000F;
        return (a << c) | (a >> (16'd16 - c));
    endfunction

`ifdef FX2_ROTM_EN
    // Word logical shift right by the negated count; counts of 32..63 clear it.
    function automatic logic [31:0] rotm_w(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] c;
        c = (32'd0 - b) & 32'h0000_003F;
        return (c >= 32'd32) ? 32'h0 : (a >> c);
    endfunction
`endif

    logic [31:0]                imm_w;
    logic [0:127]               result;
    logic [0:LAT-1]             vld_q;
    logic [0:LAT-1][RT_W-1:0]   rt_q;
    logic [0:LAT-1][0:127]      data_q;

    assign imm_w = {25'd0, pipe.imm7};

    // Stage-1 datapath: lane-wise result of the issuing op; unused ops give zero
    always_comb begin
        result = '0;
        case (pipe.issue_op)
            OP_SHL: begin
                for (int k = 0; k < 4; k++)
                    result[32*k +: 32] = shl_w(pipe.ra[32*k +: 32], pipe.rb[32*k +: 32]);
            end
            OP_SHLH: begin
                for (int h = 0; h < 8; h++)
                    result[16*h +: 16] = shl_h(pipe.ra[16*h +: 16], pipe.rb[16*h +: 16]);
            end
            OP_SHLI: begin
                for (int k = 0; k < 4; k++)
                    result[32*k +: 32] = shl_w(pipe.ra[32*k +: 32], imm_w);
            end
            OP_ROT: begin
                for (int k = 0; k < 4; k++)
                    result[32*k +: 32] = rot_w(pipe.ra[32*k +: 32], pipe.rb[32*k +: 32]);
            end
            OP_ROTH: begin
                for (int h = 0; h < 8; h++)
                    result[16*h +: 16] = rot_h(pipe.ra[16*h +: 16], pipe.rb[16*h +: 16]);
            end
            OP_ROTI: begin
                for (int k = 0; k < 4; k++)
                    result[32*k +: 32] = rot_w(pipe.ra[32*k +: 32], imm_w);
            end
`ifdef FX2_ROTM_EN
            OP_ROTM: begin
                for (int k = 0; k < 4; k++)
                    result[32*k +: 32] = rotm_w(pipe.ra[32*k +: 32], pipe.rb[32*k +: 32]);
            end
`endif
            default: result = '0;
        endcase
    end

    // Pipeline registers: flush kills every valid and outranks stall; rt/data
    // only move behind a valid so idle slots keep their old contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            rt_q   <= '0;
            data_q <= '0;
        end else if (pipe.flush) begin
            vld_q <= '0;
        end else if (!pipe.stall) begin
            vld_q <= {pipe.issue_vld, vld_q[0:LAT-2]};
            if (pipe.issue_vld) begin
                rt_q[0]   <= pipe.issue_rt;
                data_q[0] <= result;
            end
            for (int s = 1; s < LAT; s++) begin
                if (vld_q[s-1]) begin
                    rt_q[s]   <= rt_q[s-1];
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign pipe.fwd_vld  = vld_q;
    assign pipe.fwd_rt   = rt_q;
    assign pipe.fwd_data = data_q;
    assign pipe.wb_vld   = vld_q[LAT-1];
    assign pipe.wb_rt    = rt_q[LAT-1];
    assign pipe.wb_data  = data_q[LAT-1];

endmodule

// File: tb/tb_fx2_shift_pipe.sv
// tb_fx2_shift_pipe: directed and randomized checks of fx2_shift_pipe against
// a lane-arithmetic reference and a queue of in-flight ops tagged by stage.
module tb_fx2_shift_pipe;

    logic clk = 1'b0;
    logic rst_n;

    fx2_shift_pipe_if #(.RT_W(7)) pif ();

    fx2_shift_pipe #(.LAT(4), .RT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pipe  (pif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           stage;
        logic [6:0]   rt;
        logic [0:127] data;
    } op_t;

    op_t inflight[$];
    int  n_vec = 0;
    int  n_err = 0;

    // Reference result: plain arithmetic per lane (multiply for left shift,
    // divide for right shift, one-bit steps for rotation)
    function automatic logic [0:127] ref_calc(input logic [2:0] op, input logic [0:127] a,
                                              input logic [0:127] b, input logic [6:0] imm);
        logic [0:127] r;
        logic [31:0]  aw, bw, rw;
        logic [15:0]  ah, bh, rh;
        int           c;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            aw = a[32*k +: 32];
            bw = b[32*k +: 32];
            rw = 32'h0;
            case (op)
                3'd0: begin
                    c = int'(bw % 32'd64);
                    if (c < 32) rw = 32'(64'(aw) * (64'd1 << c));
                end
                3'd2: begin
                    c = int'(imm) % 64;
                    if (c < 32) rw = 32'(64'(aw) * (64'd1 << c));
                end
                3'd3: begin
                    rw = aw;
                    c  = int'(bw % 32'd32);
                    for (int i = 0; i < c; i++) rw = {rw[30:0], rw[31]};
                end
                3'd5: begin
                    rw = aw;
                    c  = int'(imm) % 32;
                    for (int i = 0; i < c; i++) rw = {rw[30:0], rw[31]};
                end
`ifdef FX2_ROTM_EN
                3'd6: begin
                    c = int'((32'd0 - bw) % 32'd64);
                    if (c < 32) rw = aw / (32'd1 << c);
                end
`endif
                default: rw = 32'h0;
            endcase
            r[32*k +: 32] = rw;
        end
        if (op == 3'd1 || op == 3'd4) begin
            for (int h = 0; h < 8; h++) begin
                ah = a[16*h +: 16];
                bh = b[16*h +: 16];
                rh = 16'h0;
                if (op == 3'd1) begin
                    c = int'(bh % 16'd32);
                    if (c < 16) rh = 16'(32'(ah) * (32'd1 << c));
                end else begin
                    rh = ah;
                    c  = int'(bh % 16'd16);
                    for (int i = 0; i < c; i++) rh = {rh[14:0], rh[15]};
                end
                r[16*h +: 16] = rh;
            end
        end
        return r;
    endfunction

    function automatic logic [0:127] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Operand B biased toward small counts so shifts are not mostly zero
    function automatic logic [0:127] rnd_cnt();
        logic [0:127] v;
        for (int k = 0; k < 4; k++)
            v[32*k +: 32] = ($urandom % 2 == 0) ? $urandom : 32'($urandom_range(0, 70));
        return v;
    endfunction

    function automatic logic [0:3] model_vld();
        logic [0:3] e;
        e = '0;
        foreach (inflight[i]) e[inflight[i].stage-1] = 1'b1;
        return e;
    endfunction

    function automatic int model_stage(input int s);
        foreach (inflight[i]) if (inflight[i].stage == s) return i;
        return -1;
    endfunction

    // Drive one cycle, advance the model at the edge, return 1 time unit later
    task automatic tick(input logic v, input logic [2:0] op, input logic [6:0] rt,
                        input logic [0:127] a, input logic [0:127] b, input logic [6:0] im,
                        input logic st, input logic fl);
        op_t nq[$];
        op_t e;
        pif.issue_vld = v;
        pif.issue_op  = op;
        pif.issue_rt  = rt;
        pif.ra        = a;
        pif.rb        = b;
        pif.imm7      = im;
        pif.stall     = st;
        pif.flush     = fl;
        @(posedge clk);
        if (fl) begin
            inflight.delete();
        end else if (!st) begin
            foreach (inflight[i]) begin
                if (inflight[i].stage < 4) begin
                    e = inflight[i];
                    e.stage++;
                    nq.push_back(e);
                end
            end
            if (v) begin
                e.stage = 1;
                e.rt    = rt;
                e.data  = ref_calc(op, a, b, im);
                nq.push_back(e);
            end
            inflight = nq;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 7'd0, '0, '0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pif.issue_vld = 1'b0; pif.issue_op = 3'd0; pif.issue_rt = 7'd0;
        pif.ra = '0; pif.rb = '0; pif.imm7 = 7'd0; pif.stall = 1'b0; pif.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (pif.fwd_vld !== 4'b0000 || pif.wb_vld !== 1'b0) begin
            n_err++; $display("FAIL reset_vld got fwd=%b wb=%b exp 0000/0", pif.fwd_vld, pif.wb_vld);
        end
        n_vec++;
        if (pif.wb_rt !== 7'd0 || pif.wb_data !== '0 || pif.fwd_rt !== '0 || pif.fwd_data !== '0) begin
            n_err++; $display("FAIL reset_data got rt=%h data=%h exp 0", pif.wb_rt, pif.wb_data);
        end
        rst_n = 1'b1;
        inflight.delete();
        idle(1);
    endtask

    task automatic test_shl();
        logic [31:0]  exp_w0 [3];
        logic [31:0]  cnt_w0 [3];
        logic [0:127] a, b;
        int           idx;
        exp_w0 = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0001};
        cnt_w0 = '{32'h1F, 32'h20, 32'h40};
        for (int i = 0; i < 3; i++) begin
            a = rnd_vec(); b = rnd_cnt();
            a[0:31] = 32'h0000_0001;
            b[0:31] = cnt_w0[i];
            tick(1'b1, 3'd0, 7'(20 + i), a, b, 7'd0, 1'b0, 1'b0);
        end
        n_vec++;
        if (pif.wb_vld !== 1'b0) begin
            n_err++; $display("FAIL shl_early wb_vld got %b exp 0", pif.wb_vld);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            idx = model_stage(4);
            n_vec++;
            if (pif.wb_vld !== 1'b1 || pif.wb_rt !== 7'(20 + i) || pif.wb_data[0:31] !== exp_w0[i]) begin
                n_err++; $display("FAIL shl_w0[%0d] got vld=%b rt=%0d w0=%h exp 1/%0d/%h",
                                  i, pif.wb_vld, pif.wb_rt, pif.wb_data[0:31], 20 + i, exp_w0[i]);
            end
            n_vec++;
            if (idx < 0 || pif.wb_data !== inflight[idx].data) begin
                n_err++; $display("FAIL shl_full[%0d] got %h exp %h", i, pif.wb_data,
                                  (idx < 0) ? 128'h0 : inflight[idx].data);
            end
        end
        idle(2);
    endtask

    task automatic test_rot();
        logic [0:127] a, b;
        logic [2:0]   ops [3];
        logic [15:0]  bh0 [3];
        int           idx;
        ops = '{3'd4, 3'd1, 3'd1};
        bh0 = '{16'h0011, 16'h0011, 16'h0001};
        for (int i = 0; i < 3; i++) begin
            a = rnd_vec(); b = rnd_cnt();
            a[0:15]  = 16'h8001;
            b[0:15]  = bh0[i];
            tick(1'b1, ops[i], 7'(30 + i), a, b, 7'd0, 1'b0, 1'b0);
            idle(3);
            idx = model_stage(4);
            n_vec++;
            if (idx < 0 || pif.wb_vld !== 1'b1 || pif.wb_data !== inflight[idx].data) begin
                n_err++; $display("FAIL rot_full[%0d] got vld=%b data=%h", i, pif.wb_vld, pif.wb_data);
            end
            if (i == 0) begin
                n_vec++;
                if (pif.wb_data[0:15] !== 16'h0003) begin
                    n_err++; $display("FAIL roth_h0 got %h exp 0003", pif.wb_data[0:15]);
                end
            end
            if (i == 2) begin
                n_vec++;
                if (pif.wb_data[0:15] !== 16'h0002) begin
                    n_err++; $display("FAIL shlh_h0 got %h exp 0002", pif.wb_data[0:15]);
                end
            end
        end
        idle(1);
    endtask

    task automatic test_rotm();
        logic [0:127] a, b;
        logic [31:0]  rbw [2];
        logic [31:0]  exp_w [2];
        rbw = '{32'hFFFF_FFFF, 32'hFFFF_FFE0};
`ifdef FX2_ROTM_EN
        exp_w = '{32'h4000_0000, 32'h0000_0000};
`else
        exp_w = '{32'h0000_0000, 32'h0000_0000};
`endif
        for (int i = 0; i < 2; i++) begin
            a = '0; b = '0;
            a[0:31] = 32'h8000_0000;
            b[0:31] = rbw[i];
            tick(1'b1, 3'd6, 7'(40 + i), a, b, 7'd0, 1'b0, 1'b0);
            idle(3);
            n_vec++;
            if (pif.wb_vld !== 1'b1 || pif.wb_rt !== 7'(40 + i) || pif.wb_data !== {exp_w[i], 96'h0}) begin
                n_err++; $display("FAIL rotm[%0d] got vld=%b rt=%0d data=%h exp w0 %h",
                                  i, pif.wb_vld, pif.wb_rt, pif.wb_data, exp_w[i]);
            end
        end
        tick(1'b1, 3'd7, 7'd42, rnd_vec(), rnd_cnt(), 7'd5, 1'b0, 1'b0);
        idle(3);
        n_vec++;
        if (pif.wb_vld !== 1'b1 || pif.wb_data !== '0) begin
            n_err++; $display("FAIL op7 got vld=%b data=%h exp 1/0", pif.wb_vld, pif.wb_data);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        int         tv [14];
        int         trt [14];
        int         tst [14];
        logic [6:0] seen[$];
        tv  = '{1, 1, 1, 1,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        trt = '{1, 2, 9, 10, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        tst = '{0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        idle(5);
        for (int i = 0; i < 14; i++) begin
            if (pif.wb_vld === 1'b1 && tst[i] == 0) seen.push_back(pif.wb_rt);
            tick(tv[i] != 0, 3'($urandom % 6), 7'(trt[i]), rnd_vec(), rnd_cnt(), 7'($urandom),
                 tst[i] != 0, 1'b0);
            n_vec++;
            if (pif.fwd_vld !== model_vld()) begin
                n_err++; $display("FAIL b2b_vld step %0d got %b exp %b", i, pif.fwd_vld, model_vld());
            end
        end
        n_vec++;
        if (seen.size() != 4) begin
            n_err++; $display("FAIL b2b_count got %0d exp 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (seen[i] !== 7'(i + 1)) begin
                    n_err++; $display("FAIL b2b_order[%0d] got %0d exp %0d", i, seen[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [0:3] exp_pre;
        exp_pre = 4'b1110;
        idle(5);
        for (int i = 0; i < 3; i++)
            tick(1'b1, 3'd3, 7'(50 + i), rnd_vec(), rnd_cnt(), 7'd0, 1'b0, 1'b0);
        n_vec++;
        if (pif.fwd_vld !== exp_pre) begin
            n_err++; $display("FAIL flush_pre got %b exp %b", pif.fwd_vld, exp_pre);
        end
        tick(1'b1, 3'd0, 7'd53, rnd_vec(), rnd_cnt(), 7'd0, 1'b1, 1'b1);
        n_vec++;
        if (pif.fwd_vld !== 4'b0000) begin
            n_err++; $display("FAIL flush_vld got %b exp 0000", pif.fwd_vld);
        end
        for (int i = 0; i < 6; i++) begin
            idle(1);
            n_vec++;
            if (pif.wb_vld !== 1'b0) begin
                n_err++; $display("FAIL flush_wb cycle %0d got wb_vld=%b rt=%0d exp 0", i, pif.wb_vld, pif.wb_rt);
            end
        end
    endtask

    task automatic test_random();
        logic [0:3] ev;
        int         s;
        int         idx;
        for (int n = 0; n < 300; n++) begin
            tick($urandom % 4 != 0, 3'($urandom), 7'($urandom), rnd_vec(), rnd_cnt(), 7'($urandom),
                 $urandom % 6 == 0, $urandom % 30 == 0);
            ev = model_vld();
            n_vec++;
            if (pif.fwd_vld !== ev) begin
                n_err++; $display("FAIL rand_vld cyc %0d got %b exp %b", n, pif.fwd_vld, ev);
            end
            foreach (inflight[i]) begin
                s = inflight[i].stage - 1;
                n_vec++;
                if (pif.fwd_rt[7*s +: 7] !== inflight[i].rt || pif.fwd_data[128*s +: 128] !== inflight[i].data) begin
                    n_err++; $display("FAIL rand_stage%0d cyc %0d got rt=%0d data=%h exp rt=%0d data=%h",
                                      s + 1, n, pif.fwd_rt[7*s +: 7], pif.fwd_data[128*s +: 128],
                                      inflight[i].rt, inflight[i].data);
                end
            end
            idx = model_stage(4);
            n_vec++;
            if (pif.wb_vld !== (idx >= 0)) begin
                n_err++; $display("FAIL rand_wbvld cyc %0d got %b exp %b", n, pif.wb_vld, idx >= 0);
            end else if (idx >= 0) begin
                n_vec++;
                if (pif.wb_rt !== inflight[idx].rt || pif.wb_data !== inflight[idx].data) begin
                    n_err++; $display("FAIL rand_wb cyc %0d got rt=%0d data=%h exp rt=%0d data=%h",
                                      n, pif.wb_rt, pif.wb_data, inflight[idx].rt, inflight[idx].data);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int idx;
        for (int i = 0; i < 5; i++)
            tick(1'b1, 3'd5, 7'(60 + i), rnd_vec(), rnd_cnt(), 7'($urandom), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (pif.fwd_vld !== 4'b0000 || pif.wb_vld !== 1'b0 || pif.wb_rt !== 7'd0 || pif.wb_data !== '0) begin
            n_err++; $display("FAIL async_rst got vld=%b wb=%b rt=%0d data=%h exp all 0",
                              pif.fwd_vld, pif.wb_vld, pif.wb_rt, pif.wb_data);
        end
        pif.issue_vld = 1'b0;
        inflight.delete();
        @(posedge clk);
        #1;
        n_vec++;
        if (pif.fwd_vld !== 4'b0000 || pif.fwd_data !== '0) begin
            n_err++; $display("FAIL async_rst_hold got vld=%b exp 0000", pif.fwd_vld);
        end
        rst_n = 1'b1;
        tick(1'b1, 3'd3, 7'd77, rnd_vec(), rnd_cnt(), 7'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            n_vec++;
            if (pif.wb_vld !== 1'b0) begin
                n_err++; $display("FAIL restart_early cyc %0d got wb_vld=%b exp 0", i, pif.wb_vld);
            end
        end
        idle(1);
        idx = model_stage(4);
        n_vec++;
        if (idx < 0 || pif.wb_vld !== 1'b1 || pif.wb_rt !== 7'd77 || pif.wb_data !== inflight[idx].data) begin
            n_err++; $display("FAIL restart_wb got vld=%b rt=%0d data=%h exp 1/77", pif.wb_vld, pif.wb_rt, pif.wb_data);
        end
    endtask

    initial begin
        test_reset();
        test_shl();
        test_rot();
        test_rotm();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
